// File: rtl/operand_stack_pkg.sv
// -----------------------------------------------------------------------------
// operand_stack_pkg
// Shared definitions for the stack CPU operand stack: default sizes, the
// occupancy-count width helper and the stack command encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package operand_stack_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int STACK_DEPTH_DEF = 16;

    // The count must represent 0..depth inclusive, hence depth+1 codes.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int CNT_WIDTH_DEF = $clog2(STACK_DEPTH_DEF + 1);

    // Encodings 6 and 7 are unused and behave as NOP.
    typedef enum logic [2:0] {
        NOP       = 3'd0,
        PUSH      = 3'd1,
        POP1      = 3'd2,
        POP2      = 3'd3,
        POP1_PUSH = 3'd4,
        POP2_PUSH = 3'd5
    } stack_cmd_t;

endpackage

// File: rtl/operand_stack_if.sv
// -----------------------------------------------------------------------------
// operand_stack_if
// Command/response bundle between the control FSM (master) and the operand
// stack (slave).
//   master -> slave : cmd, push_data, clear
//   slave -> master : tos, nos, count, empty, full, overflow, underflow,
//                     cmd_ack
// Handshake: the master presents one cmd per clock, it is sampled at the next
// rising edge; there is no back-pressure. cmd_ack is high for exactly one
// cycle after a command was accepted and stays low for NOP, for a rejected
// command and for a cycle with clear asserted.
// -----------------------------------------------------------------------------
interface operand_stack_if import operand_stack_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) ();

    stack_cmd_t            cmd;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  clear;
    logic [DATA_WIDTH-1:0] tos;
    logic [DATA_WIDTH-1:0] nos;
    logic [CNT_WIDTH-1:0]  count;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic                  underflow;
    logic                  cmd_ack;

    modport master (
        output cmd, push_data, clear,
        input  tos, nos, count, empty, full, overflow, underflow, cmd_ack
    );

    modport slave (
        input  cmd, push_data, clear,
        output tos, nos, count, empty, full, overflow, underflow, cmd_ack
    );

endinterface

// File: rtl/operand_stack.sv
// -----------------------------------------------------------------------------
// operand_stack
// LIFO operand stack for the stack CPU. One command per clock; the top two
// entries are presented combinationally from registered state to the ALU.
// Rejected pushes/pops leave the stack untouched and set sticky error flags.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : operand_stack_if.slave (cmd, push_data, clear in;
//           tos, nos, count, empty, full, overflow, underflow, cmd_ack out)
// -----------------------------------------------------------------------------
module operand_stack import operand_stack_pkg::*; #(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input logic            clk,
    input logic            reset,
    operand_stack_if.slave bus
);

    localparam int CNT_WIDTH = cnt_width(STACK_DEPTH);
    localparam int IDX_WIDTH = $clog2(STACK_DEPTH);

    localparam logic [CNT_WIDTH-1:0] C_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] C_TWO   = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] C_DEPTH = CNT_WIDTH'(STACK_DEPTH);

    // State
    logic [DATA_WIDTH-1:0] r_mem [STACK_DEPTH];
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_cmd_ack;

    // Decode
    logic                  w_has1;
    logic                  w_has2;
    logic                  w_full;
    logic [IDX_WIDTH-1:0]  w_push_idx;
    logic [IDX_WIDTH-1:0]  w_top_idx;
    logic [IDX_WIDTH-1:0]  w_nos_idx;
    logic                  w_accept;
    logic                  w_set_ovf;
    logic                  w_set_udf;
    logic                  w_wr_en;
    logic [IDX_WIDTH-1:0]  w_wr_idx;
    logic [CNT_WIDTH-1:0]  w_next_count;

    assign w_has1 = (r_count >= C_ONE);
    assign w_has2 = (r_count >= C_TWO);
    assign w_full = (r_count == C_DEPTH);

    // r_count is the write pointer. The truncations are exact whenever the
    // corresponding index is actually used (guarded by w_has1/w_has2/w_full).
    assign w_push_idx = IDX_WIDTH'(r_count);
    assign w_top_idx  = IDX_WIDTH'(r_count - C_ONE);
    assign w_nos_idx  = IDX_WIDTH'(r_count - C_TWO);

    // Every command is checked in full before anything is changed, so a
    // rejected command (including POP2_PUSH at count 1) has no partial effect.
    always_comb begin
        w_accept     = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_udf    = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_idx     = w_push_idx;
        w_next_count = r_count;
        case (bus.cmd)
            PUSH: begin
                if (!w_full) begin
                    w_accept     = 1'b1;
                    w_wr_en      = 1'b1;
                    w_wr_idx     = w_push_idx;
                    w_next_count = r_count + C_ONE;
                end else begin
                    w_set_ovf = 1'b1;
                end
            end
            POP1: begin
                if (w_has1) begin
                    w_accept     = 1'b1;
                    w_next_count = r_count - C_ONE;
                end else begin
                    w_set_udf = 1'b1;
                end
            end
            POP2: begin
                if (w_has2) begin
                    w_accept     = 1'b1;
                    w_next_count = r_count - C_TWO;
                end else begin
                    w_set_udf = 1'b1;
                end
            end
            POP1_PUSH: begin
                // Net count change is zero, so this is legal when full.
                if (w_has1) begin
                    w_accept = 1'b1;
                    w_wr_en  = 1'b1;
                    w_wr_idx = w_top_idx;
                end else begin
                    w_set_udf = 1'b1;
                end
            end
            POP2_PUSH: begin
                if (w_has2) begin
                    w_accept     = 1'b1;
                    w_wr_en      = 1'b1;
                    w_wr_idx     = w_nos_idx;
                    w_next_count = r_count - C_ONE;
                end else begin
                    w_set_udf = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control state: clear wins over any command issued in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_cmd_ack   <= 1'b0;
        end else if (bus.clear) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_cmd_ack   <= 1'b0;
        end else begin
            r_count     <= w_next_count;
            r_overflow  <= r_overflow | w_set_ovf;
            r_underflow <= r_underflow | w_set_udf;
            r_cmd_ack   <= w_accept;
        end
    end

    // Storage has no reset: stale contents are hidden by the count masking.
    always_ff @(posedge clk) begin
        if (w_wr_en && !bus.clear) begin
            r_mem[w_wr_idx] <= bus.push_data;
        end
    end

    assign bus.tos       = w_has1 ? r_mem[w_top_idx] : '0;
    assign bus.nos       = w_has2 ? r_mem[w_nos_idx] : '0;
    assign bus.count     = r_count;
    assign bus.empty     = (r_count == '0);
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
    assign bus.cmd_ack   = r_cmd_ack;

endmodule

// File: tb/tb_operand_stack.sv
// -----------------------------------------------------------------------------
// tb_operand_stack
// Directed bench for operand_stack. The driver issues one command per cycle
// and queues the hand-computed state expected after it; a monitor pops one
// entry per cycle and compares every output.
// -----------------------------------------------------------------------------
module tb_operand_stack;
    import operand_stack_pkg::*;

    typedef struct packed {
        logic [31:0] tos;
        logic [31:0] nos;
        logic [4:0]  count;
        logic        ovf;
        logic        udf;
        logic        ack;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    operand_stack_if #(.DATA_WIDTH(32), .CNT_WIDTH(5)) bus ();

    operand_stack #(.DATA_WIDTH(32), .STACK_DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag, input exp_t e);
        check({tag, ".tos"},       bus.tos,       e.tos);
        check({tag, ".nos"},       bus.nos,       e.nos);
        check({tag, ".count"},     32'(bus.count), 32'(e.count));
        check({tag, ".empty"},     32'(bus.empty), 32'(e.count == 5'd0));
        check({tag, ".full"},      32'(bus.full),  32'(e.count == 5'd16));
        check({tag, ".overflow"},  32'(bus.overflow),  32'(e.ovf));
        check({tag, ".underflow"}, 32'(bus.underflow), 32'(e.udf));
        check({tag, ".cmd_ack"},   32'(bus.cmd_ack),   32'(e.ack));
    endtask

    // Driver: present a command for one cycle and queue the expected result.
    task automatic step(input stack_cmd_t c, input logic [31:0] d, input logic clr,
                        input logic [31:0] t, input logic [31:0] n, input logic [4:0] cnt,
                        input logic o, input logic u, input logic a);
        exp_t e;
        @(posedge clk);
        #2;
        bus.cmd       = c;
        bus.push_data = d;
        bus.clear     = clr;
        e.tos   = t;
        e.nos   = n;
        e.count = cnt;
        e.ovf   = o;
        e.udf   = u;
        e.ack   = a;
        exp_q.push_back(e);
    endtask

    // Monitor: one queued expectation per clock, sampled after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_state("step", e);
            end
        end
    end

    initial begin
        exp_t rst_e;
        rst_e = '0;
        reset         = 1'b1;
        bus.cmd       = NOP;
        bus.push_data = '0;
        bus.clear     = 1'b0;
        #3;
        check_state("reset", rst_e);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // 1: two pushes
        step(PUSH, 32'h5, 1'b0, 32'h5, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1);
        step(PUSH, 32'h3, 1'b0, 32'h3, 32'h5, 5'd2, 1'b0, 1'b0, 1'b1);
        // 2: ALU-style POP2_PUSH
        step(POP2_PUSH, 32'h8, 1'b0, 32'h8, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1);
        step(NOP, 32'h0, 1'b0, 32'h8, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0);
        step(POP1, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);

        // 3: fill to 16, overflow, replace top when full, POP2_PUSH when full
        for (int i = 1; i <= 16; i++)
            step(PUSH, 32'(i), 1'b0, 32'(i), 32'(i - 1), 5'(i), 1'b0, 1'b0, 1'b1);
        step(PUSH, 32'hDEAD, 1'b0, 32'd16, 32'd15, 5'd16, 1'b1, 1'b0, 1'b0);
        step(POP1_PUSH, 32'h77, 1'b0, 32'h77, 32'd15, 5'd16, 1'b1, 1'b0, 1'b1);
        step(POP2_PUSH, 32'h99, 1'b0, 32'h99, 32'd14, 5'd15, 1'b1, 1'b0, 1'b1);

        // 4: underflow cases
        step(NOP, 32'h0, 1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(POP1, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(PUSH, 32'h9, 1'b0, 32'h9, 32'h0, 5'd1, 1'b0, 1'b1, 1'b1);
        step(POP2_PUSH, 32'h55, 1'b0, 32'h9, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0);
        step(POP2, 32'h0, 1'b0, 32'h9, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0);
        step(stack_cmd_t'(3'd6), 32'h66, 1'b0, 32'h9, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0);
        step(stack_cmd_t'(3'd7), 32'h67, 1'b0, 32'h9, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0);

        // 5: clear beats a simultaneous push
        step(PUSH, 32'h10, 1'b0, 32'h10, 32'h9, 5'd2, 1'b0, 1'b1, 1'b1);
        step(PUSH, 32'h11, 1'b0, 32'h11, 32'h10, 5'd3, 1'b0, 1'b1, 1'b1);
        step(PUSH, 32'h22, 1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(NOP, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(PUSH, 32'h30, 1'b0, 32'h30, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1);

        // 6: asynchronous reset mid-cycle with count=4 and a PUSH pending
        step(PUSH, 32'h31, 1'b0, 32'h31, 32'h30, 5'd2, 1'b0, 1'b0, 1'b1);
        step(PUSH, 32'h32, 1'b0, 32'h32, 32'h31, 5'd3, 1'b0, 1'b0, 1'b1);
        step(PUSH, 32'h33, 1'b0, 32'h33, 32'h32, 5'd4, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        bus.cmd       = PUSH;
        bus.push_data = 32'hEE;
        bus.clear     = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_state("async_reset", rst_e);
        @(posedge clk);
        #2;
        reset   = 1'b0;
        bus.cmd = NOP;
        step(PUSH, 32'hAB, 1'b0, 32'hAB, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1);
        step(NOP, 32'h0, 1'b0, 32'hAB, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- LIFO operand stack for the stack CPU. It holds 32-bit operands pushed by PUSH_IMMEDIATE and by ALU results.
- Exposes the top two entries combinationally to the ALU.
- Executes one stack command per clock, issued by the control FSM in its POP2/POP1/PUSH states.
- Detects overflow and underflow and reports them as sticky error flags.

Parameters:
DATA_WIDTH, DATA_WIDTH_DEF (32), width of each stack entry
STACK_DEPTH, STACK_DEPTH_DEF (16), number of entries; must be >= 2
CNT_WIDTH, $clog2(STACK_DEPTH+1), width of the occupancy count (5 by default)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
cmd  input  3  stack_cmd_t command, executed at the next rising edge
push_data  input  DATA_WIDTH  value written by any command that includes a push
clear  input  1  synchronous flush: empties the stack and clears the error flags
tos  output  DATA_WIDTH  top-of-stack entry; 0 when count < 1
nos  output  DATA_WIDTH  next-on-stack entry; 0 when count < 2
count  output  CNT_WIDTH  current number of valid entries
empty  output  1  count == 0
full  output  1  count == STACK_DEPTH
overflow  output  1  sticky; set by a rejected push
underflow  output  1  sticky; set by a rejected pop
cmd_ack  output  1  registered; 1 for one cycle after a command is accepted

Behaviour:
- Reset (asynchronous, any time, including mid-command):
  - count=0, so empty=1 and full=0.
  - overflow=0, underflow=0, cmd_ack=0.
  - Storage contents are don't-care; tos=0 and nos=0 because they are masked by count.
- Storage and outputs:
  - Register array with a write pointer equal to count.
  - tos = mem[count-1], nos = mem[count-2].
  - tos, nos, count, empty and full are combinational from registered state, so there is zero-latency read.
  - Each command takes effect at one edge and is visible in the cycle after.
- Commands (stack_cmd_t):
  - NOP: no change, cmd_ack=0.
  - PUSH: requires count < DEPTH. Writes mem[count]=push_data; count+1.
  - POP1: requires count >= 1. count-1.
  - POP2: requires count >= 2. count-2.
  - POP1_PUSH: requires count >= 1. Replaces the top: mem[count-1]=push_data; count unchanged. Legal when full.
  - POP2_PUSH: requires count >= 2. mem[count-2]=push_data; count-1. Legal when full.
- Rejected command:
  - Storage and count are unchanged and cmd_ack=0.
  - The relevant sticky flag is set: overflow for PUSH when full; underflow for any pop with insufficient entries.
  - POP2_PUSH with count==1 is rejected entirely as underflow; there is no partial pop.
- Accepted command: cmd_ack=1 in the following cycle.
- Sticky flags stay set until clear or reset. Later legal commands still execute normally.
- clear: takes precedence over cmd that cycle. count=0, flags=0, cmd_ack=0; cmd is ignored.
- Undefined cmd encodings (6, 7) are treated as NOP.
- count never wraps; its arithmetic is guarded by the acceptance checks above.
- No combinational path from cmd or push_data to any output.

Decomposition:
- Add to the shared stackCPU_DEFS package:
  - typedef enum logic [2:0] stack_cmd_t {NOP=0, PUSH=1, POP1=2, POP2=3, POP1_PUSH=4, POP2_PUSH=5}.
  - The CNT_WIDTH expression as a package constant.
- No sub-module. The storage array, count register and flag logic are inline in operand_stack.

Test Plan:
1. Reset, then PUSH 0x0000_0005, then PUSH 0x0000_0003 -> count=2, tos=3, nos=5, empty=0, cmd_ack pulses once per push.
2. From (1), POP2_PUSH with push_data=8, mimicking ADD -> count=1, tos=8, nos=0, no flags set.
3. Push 16 distinct values (1..16) -> full=1, tos=16. A 17th PUSH of 0xDEAD -> overflow=1, tos still 16, count=16, cmd_ack=0. Then POP1_PUSH 0x77 -> tos=0x77, count=16.
4. Empty stack, POP1 -> underflow=1, count=0. Then PUSH 9 -> count=1, underflow still 1. Then POP2_PUSH -> rejected, tos=9, count=1.
5. clear asserted together with cmd=PUSH at count=3 with flags set -> count=0, empty=1, overflow=underflow=0, push ignored.
6. Assert reset asynchronously mid-cycle with count=4 and a PUSH pending -> outputs go to reset values immediately, without waiting for a clock edge. After release, the first PUSH lands at count=1.
